// File: rtl/window_line_buffer.sv
// Sliding-window line buffer: emits a NUM_ROWS-tall pixel column per input beat.
// Ports: clk, rst (sync, active-high); cfg_width latched on sof beats;
//   in_valid/in_ready/sof/din pixel input; out_valid/out_ready handshake;
//   dout = column (slice 0 newest line, in LSBs), out_col, out_eol, out_primed.
// Option: define WLB_BORDER_REPLICATE_EN to fill unfilled rows with the top
//   frame row instead of zeros.
module window_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 128,
  parameter int NUM_ROWS   = 4,
  localparam int CW = $clog2(MAX_WIDTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CW-1:0]                  cfg_width,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sof,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]                  out_col,
  output logic                           out_eol,
  output logic                           out_primed
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam int LW = $clog2(NUM_ROWS);
  localparam int NS = NUM_ROWS - 1;
  localparam logic [CW-1:0] MAXW = CW'(MAX_WIDTH);
  localparam logic [LW-1:0] LMAX = LW'(NS);

  logic [DATA_WIDTH-1:0] store_q [NS][MAX_WIDTH];

  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] lines_q, lines_d;
  logic [CW-1:0] wlat_q;
  logic          ov_q;
  logic [NUM_ROWS*DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0] ocol_q;
  logic          oeol_q, oprim_q;

  logic                  beat;
  logic [CW-1:0]         wcfg, c_b, w_b;
  logic [LW-1:0]         l_b;
  logic [AW-1:0]         idx;
  logic                  eol_b;
  logic [DATA_WIDTH-1:0] tap [NUM_ROWS];

  assign in_ready   = !ov_q || out_ready;
  assign beat       = in_valid && in_ready;
  assign out_valid  = ov_q;
  assign dout       = dout_q;
  assign out_col    = ocol_q;
  assign out_eol    = oeol_q;
  assign out_primed = oprim_q;

  // Out-of-range widths fall back to the full line.
  assign wcfg = (cfg_width == '0 || cfg_width > MAXW) ? MAXW : cfg_width;

  // A sof beat restarts position and takes the new width immediately.
  assign c_b   = sof ? '0 : col_q;
  assign l_b   = sof ? '0 : lines_q;
  assign w_b   = sof ? wcfg : wlat_q;
  assign idx   = c_b[AW-1:0];
  assign eol_b = (c_b == w_b - 1'b1);

  always_comb begin
    tap[0] = din;
    for (int k = 1; k < NUM_ROWS; k++) begin
      tap[k] = store_q[k-1][idx];
    end
  end

  always_comb begin
    col_d   = eol_b ? '0 : c_b + 1'b1;
    lines_d = (eol_b && l_b != LMAX) ? l_b + 1'b1 : l_b;
  end

  // Rows older than the frame itself hold stale data and are masked.
  always_comb begin
    dout_d = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (k <= int'(l_b)) begin
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
      end else begin
`ifdef WLB_BORDER_REPLICATE_EN
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = tap[l_b];
`else
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      lines_q <= '0;
      wlat_q  <= MAXW;
      ov_q    <= 1'b0;
      dout_q  <= '0;
      ocol_q  <= '0;
      oeol_q  <= 1'b0;
      oprim_q <= 1'b0;
    end else if (beat) begin
      col_q   <= col_d;
      lines_q <= lines_d;
      wlat_q  <= w_b;
      ov_q    <= 1'b1;
      dout_q  <= dout_d;
      ocol_q  <= c_b;
      oeol_q  <= eol_b;
      oprim_q <= (l_b == LMAX);
    end else if (out_ready) begin
      ov_q    <= 1'b0;
    end
  end

  // Each column shifts one row down its stack per beat.
  always_ff @(posedge clk) begin
    if (beat && !rst) begin
      for (int k = 0; k < NS; k++) begin
        store_q[k][idx] <= tap[k];
      end
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Self-checking bench for window_line_buffer (NUM_ROWS=4, MAX_WIDTH=8).
// Frame-history model checked every cycle plus literal expectations.
module tb_window_line_buffer;

  localparam int DW = 8;
  localparam int MW = 8;
  localparam int NR = 4;
  localparam int CW = $clog2(MW + 1);
`ifdef WLB_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_width;
  logic          in_valid, in_ready, sof;
  logic [DW-1:0] din;
  logic          out_valid, out_ready;
  logic [NR*DW-1:0] dout;
  logic [CW-1:0] out_col;
  logic          out_eol, out_primed;

  window_line_buffer #(
    .DATA_WIDTH(DW), .MAX_WIDTH(MW), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width),
    .in_valid(in_valid), .in_ready(in_ready), .sof(sof), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_col(out_col), .out_eol(out_eol), .out_primed(out_primed)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  // Model: hist[line][col] holds every pixel of the current frame.
  logic [DW-1:0]    hist [64][MW];
  int               mcol, mline, mw;
  bit               ev, eeol, eprim;
  logic [NR*DW-1:0] ed;
  int               ecol;

  always @(posedge clk) begin
    int c, l, w;
    bit rdy;
    rdy = !ev || out_ready;
    if (rst) begin
      ev = 0; ed = '0; ecol = 0; eeol = 0; eprim = 0;
      mcol = 0; mline = 0; mw = MW;
    end else if (in_valid && rdy) begin
      c = sof ? 0 : mcol;
      l = sof ? 0 : mline;
      if (sof) w = (cfg_width == 0 || int'(cfg_width) > MW) ? MW : int'(cfg_width);
      else w = mw;
      hist[l][c] = din;
      for (int k = 0; k < NR; k++) begin
        if (k <= l) ed[k*DW +: DW] = hist[l-k][c];
        else ed[k*DW +: DW] = REP ? hist[0][c] : '0;
      end
      ecol = c; eeol = (c == w - 1); eprim = (l >= NR - 1); ev = 1;
      if (eeol) begin mcol = 0; mline = l + 1; end
      else begin mcol = c + 1; mline = l; end
      mw = w;
    end else if (out_ready) begin
      ev = 0;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      chk("dout", dout, ed);
      chk("out_col", out_col, ecol);
      chk("out_eol", out_eol, eeol);
      chk("out_primed", out_primed, eprim);
    end
  end

  task automatic send(input logic [DW-1:0] p, input logic s);
    int n;
    n = 0;
    in_valid = 1; din = p; sof = s;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 (pixel %0h)", p);
    end
    @(posedge clk); #1;
    in_valid = 0; sof = 0;
  endtask

  logic [NR*DW-1:0] hold_d;
  logic [CW-1:0]    hold_c;

  initial begin
    rst = 1; in_valid = 0; sof = 0; din = 0;
    cfg_width = 4; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0; en = 1;

    // 4-wide frame of 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), i == 1);
      if (i == 2) cfg_width = 7;
      if (i == 6)
        chk("border_px06", dout, REP ? 32'h02020206 : 32'h00000206);
      if (i == 13) begin
        chk("px0d_dout", dout, 32'h0105090D);
        chk("px0d_primed", out_primed, 1);
        chk("px0d_col", out_col, 0);
      end
    end

    // Backpressure for 5 cycles mid-line
    send(8'h11, 0);
    out_ready = 0;
    hold_d = dout; hold_c = out_col;
    in_valid = 1; din = 8'h12;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_dout", dout, hold_d);
      chk("stall_col", out_col, hold_c);
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("release_col", out_col, 1);
    chk("release_px", dout[7:0], 8'h12);
    send(8'h13, 0);
    chk("after_release_col", out_col, 2);

    // Width-3 frame aborted at col 2 of line 3
    cfg_width = 3;
    for (int i = 0; i < 11; i++) begin
      send(8'(8'h20 + i), i == 0);
      if (i == 0) cfg_width = 6;
    end
    chk("pre_abort_col", out_col, 1);
    cfg_width = 3;
    send(8'h40, 1);
    chk("abort_col", out_col, 0);
    chk("abort_primed", out_primed, 0);
    send(8'h41, 0);
    chk("abort_no_eol", out_eol, 0);
    send(8'h42, 0);
    chk("abort_eol", out_eol, 1);
    for (int i = 3; i < 9; i++) send(8'(8'h40 + i), 0);

    // cfg_width 0 and oversize widths -> full line
    cfg_width = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h80 + i), i == 0);
      if (i == 6) chk("w0_no_eol", out_eol, 0);
    end
    chk("w0_col7", out_col, 7);
    chk("w0_eol", out_eol, 1);
    cfg_width = 12;
    for (int i = 0; i < 16; i++) send(8'(8'h90 + i), i == 0);

    // Reset with an output pending and a beat offered
    cfg_width = 4;
    send(8'h50, 1);
    in_valid = 1; din = 8'h51; rst = 1;
    @(posedge clk); #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_dout", dout, 0);
    chk("rst2_in_ready", in_ready, 1);
    rst = 0; in_valid = 0;
    send(8'h60, 1);
    chk("restart_primed", out_primed, 0);
    chk("restart_col", out_col, 0);
    chk("restart_dout", dout, REP ? 32'h60606060 : 32'h00000060);
    for (int i = 1; i < 8; i++) send(8'(8'h60 + i), 0);

    repeat (3) @(posedge clk);
    #1;
    en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
